pcpi_initiator: RTL

Initiator (CPU-side master) for the PCPI coprocessor interface. It accepts one custom/M-extension instruction at a time on a valid/ready request port and drives pcpi_valid/insn/rs1/rs2 to all attached coprocessors. It collects the pcpi_ready/pcpi_wr/pcpi_rd response, or reports an illegal instruction when no coprocessor claims it within a timeout. It sits between the core's execute stage (or a bench harness) and the coprocessor bus that the multiplier and divider responders hang on.

---
 rtl/pcpi_pkg.sv | 24 ++
 rtl/pcpi_watchdog.sv | 25 ++
 rtl/pcpi_initiator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: initiator state encoding and the RV32M opcode fields
// that the initiator benches and the coprocessor responders both decode.
package pcpi_pkg;

  typedef enum logic [1:0] {
    GAP,
    IDLE,
    ISSUE,
    RESP
  } pcpi_state_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

endpackage

// File: rtl/pcpi_watchdog.sv
// Saturating 8-bit idle-cycle counter; o_expired once TIMEOUT_CYCLES
// enabled cycles have elapsed since the last clear.
module pcpi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count >= 8'(TIMEOUT_CYCLES));

endmodule

// File: rtl/pcpi_initiator.sv
// PCPI bus master: issues one instruction at a time to the coprocessors and
// returns either the claimed result or an illegal-instruction response.
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic        rsp_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  pcpi_state_e r_state;
  pcpi_state_e w_state_nxt;
  logic [7:0]  r_gap_cnt;

  logic        w_wd_expired;
  logic        w_timeout;
  logic        w_accept;
  logic        w_complete;
  logic        w_rsp_hs;
  logic        w_gap_done;
  logic        w_req_ready_nxt;
  logic [31:0] w_rsp_rd_nxt;
  logic        w_rsp_wr_nxt;
  logic        w_rsp_ill_nxt;

  // The counter only runs in ISSUE; any cycle with pcpi_wait high restarts it.
  pcpi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  ((r_state != ISSUE) || pcpi_wait),
    .i_enable (!pcpi_ready),
    .o_expired(w_wd_expired)
  );

  assign w_timeout  = w_wd_expired && !pcpi_wait;
  assign w_gap_done = (r_gap_cnt >= 8'(GAP_CYCLES)) && !pcpi_wait;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= GAP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      GAP:     if (w_gap_done)               w_state_nxt = IDLE;
      IDLE:    if (req_valid && req_ready)   w_state_nxt = ISSUE;
      ISSUE:   if (pcpi_ready || w_timeout)  w_state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready)   w_state_nxt = GAP;
      default:                               w_state_nxt = GAP;
    endcase
  end

  // pcpi_ready takes priority over a timeout expiring in the same cycle.
  always_comb begin
    w_accept        = (r_state == IDLE) && req_valid && req_ready;
    w_complete      = (r_state == ISSUE) && (pcpi_ready || w_timeout);
    w_rsp_hs        = (r_state == RESP) && rsp_valid && rsp_ready;
    w_req_ready_nxt = (w_state_nxt == IDLE);
    w_rsp_rd_nxt    = pcpi_ready ? pcpi_rd : '0;
    w_rsp_wr_nxt    = pcpi_ready && pcpi_wr;
    w_rsp_ill_nxt   = !pcpi_ready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_gap_cnt   <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rd      <= '0;
      rsp_wr      <= 1'b0;
      rsp_illegal <= 1'b0;
      pcpi_valid  <= 1'b0;
      pcpi_insn   <= '0;
      pcpi_rs1    <= '0;
      pcpi_rs2    <= '0;
    end else begin
      req_ready <= w_req_ready_nxt;
      if (r_state == GAP) begin
        if (r_gap_cnt != '1) r_gap_cnt <= r_gap_cnt + 8'd1;
      end else begin
        r_gap_cnt <= '0;
      end
      if (w_accept) begin
        pcpi_insn  <= req_insn;
        pcpi_rs1   <= req_rs1;
        pcpi_rs2   <= req_rs2;
        pcpi_valid <= 1'b1;
      end
      if (w_complete) begin
        pcpi_valid  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rd      <= w_rsp_rd_nxt;
        rsp_wr      <= w_rsp_wr_nxt;
        rsp_illegal <= w_rsp_ill_nxt;
      end
      if (w_rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
